// File: rtl/mcc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcc_pkg
//  Description : Shared opcode, state, ALU-op, PC-select and register-select
//                constants for the multi-cycle controller, ALU and datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcc_pkg;

   // Instruction opcodes (halt is a parameter of the controller)
   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b000001;
   localparam logic [5:0] OP_ORI  = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_OR   = 6'b010010;
   localparam logic [5:0] OP_SLT  = 6'b011000;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_JR   = 6'b111001;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;

   // Next-PC select
   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_REG    = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   // Write-register select
   localparam logic [1:0] RD_RA = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RD = 2'b10;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_AL = 4'd2,
      S_WB_AL  = 4'd3,
      S_EXE_BR = 4'd4,
      S_EXE_LS = 4'd5,
      S_MEM    = 4'd6,
      S_WB_LD  = 4'd7,
      S_HALT   = 4'd8
   } state_e;

   // Instruction families that share a path through the FSM
   typedef enum logic [2:0] {
      CL_ALU  = 3'd0,
      CL_BR   = 3'd1,
      CL_LS   = 3'd2,
      CL_JUMP = 3'd3,   // j/jal/jr and every undefined opcode
      CL_HALT = 3'd4
   } op_class_e;

   typedef struct packed {
      logic       PCWre;
      logic       IRWre;
      logic       InsMemRW;
      logic       DataMemRW;
      logic       RegWre;
      logic       ALUSrcB;
      logic       ExtSel;
      logic       WrRegDSrc;
      logic       ALUM2Reg;
      logic [1:0] RegDst;
      logic [1:0] PCSrc;
      logic [2:0] ALUOp;
   } ctrl_t;

   // Halt is checked first so a custom halt opcode overrides any other decode
   function automatic op_class_e op_class(input logic [5:0] op, input logic [5:0] halt_op);
      if (op == halt_op) return CL_HALT;
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_ORI,
         OP_AND, OP_OR, OP_SLT:           return CL_ALU;
         OP_BEQ:                          return CL_BR;
         OP_SW, OP_LW:                    return CL_LS;
         default:                         return CL_JUMP;
      endcase
   endfunction

   function automatic logic is_rtype(input logic [5:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_SLT);
   endfunction

   function automatic logic [2:0] alu_op_of(input logic [5:0] op);
      case (op)
         OP_SUB, OP_BEQ: return ALU_SUB;
         OP_OR, OP_ORI:  return ALU_OR;
         OP_AND:         return ALU_AND;
         OP_SLT:         return ALU_SLT;
         default:        return ALU_ADD;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mcc_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcc_if
//  Description : Controller <-> datapath bundle: opcode/flag in, enables,
//                selects, debug state and counters out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mcc_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       op;
   logic             zero;
   logic             PCWre, IRWre, InsMemRW, DataMemRW, RegWre;
   logic             ALUSrcB, ExtSel, WrRegDSrc, ALUM2Reg;
   logic [1:0]       RegDst;
   logic [1:0]       PCSrc;
   logic [2:0]       ALUOp;
   logic [3:0]       state;
   logic [CNT_W-1:0] retired;
   logic [CNT_W-1:0] cycles;

   modport master (
      input  op, zero,
      output PCWre, IRWre, InsMemRW, DataMemRW, RegWre,
             ALUSrcB, ExtSel, WrRegDSrc, ALUM2Reg,
             RegDst, PCSrc, ALUOp, state, retired, cycles
   );

   modport slave (
      output op, zero,
      input  PCWre, IRWre, InsMemRW, DataMemRW, RegWre,
             ALUSrcB, ExtSel, WrRegDSrc, ALUM2Reg,
             RegDst, PCSrc, ALUOp, state, retired, cycles
   );
endinterface
`default_nettype wire

// File: rtl/mcc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mcc_decode
//  Description : Purely combinational control decode from (state, op, zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module mcc_decode
   import mcc_pkg::*;
#(
   parameter logic [5:0] HALT_OP = 6'b111111
) (
   input  state_e     state_i,
   input  logic [5:0] op_i,
   input  logic       zero_i,
   output ctrl_t      ctrl_o
);

   op_class_e w_cls;
   assign w_cls = op_class(op_i, HALT_OP);

   // Operand selects follow the opcode; enables follow the state
   always_comb begin
      ctrl_o           = '0;
      ctrl_o.WrRegDSrc = 1'b1;
      ctrl_o.ALUSrcB   = (op_i == OP_ADDI) || (op_i == OP_ORI) ||
                         (op_i == OP_SW)   || (op_i == OP_LW);
      ctrl_o.ExtSel    = (op_i != OP_ORI);
      ctrl_o.ALUOp     = alu_op_of(op_i);
      case (state_i)
         S_IF: ctrl_o.IRWre = 1'b1;
         S_ID: begin
            if (w_cls == CL_JUMP) begin
               ctrl_o.PCWre = 1'b1;
               if (op_i == OP_J || op_i == OP_JAL) ctrl_o.PCSrc = PC_JUMP;
               else if (op_i == OP_JR)              ctrl_o.PCSrc = PC_REG;
               if (op_i == OP_JAL) begin
                  ctrl_o.RegWre    = 1'b1;
                  ctrl_o.RegDst    = RD_RA;
                  ctrl_o.WrRegDSrc = 1'b0;
               end
            end
         end
         S_WB_AL: begin
            ctrl_o.RegWre = 1'b1;
            ctrl_o.RegDst = is_rtype(op_i) ? RD_RD : RD_RT;
            ctrl_o.PCWre  = 1'b1;
         end
         S_EXE_BR: begin
            ctrl_o.PCWre = 1'b1;
            ctrl_o.PCSrc = zero_i ? PC_BRANCH : PC_NEXT;
            ctrl_o.ALUOp = ALU_SUB;
         end
         S_MEM: begin
            // A store retires here; a load continues to write-back
            ctrl_o.DataMemRW = (op_i == OP_SW);
            ctrl_o.PCWre     = (op_i != OP_LW);
         end
         S_WB_LD: begin
            ctrl_o.RegWre   = 1'b1;
            ctrl_o.RegDst   = RD_RT;
            ctrl_o.ALUM2Reg = 1'b1;
            ctrl_o.PCWre    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_control
//  Description : Multi-cycle CPU controller: state register, next-state
//                logic, retired/cycle counters and the control decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_control
   import mcc_pkg::*;
#(
   parameter logic [5:0] HALT_OP = 6'b111111,
   parameter int         CNT_W   = 32
) (
   input  logic   CLK,
   input  logic   Reset,
   mcc_if.master  bus
);

   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q, cycles_q;
   ctrl_t            w_ctrl;
   op_class_e        w_cls;

   assign w_cls = op_class(bus.op, HALT_OP);

   mcc_decode #(.HALT_OP(HALT_OP)) u_decode (
      .state_i (state_q),
      .op_i    (bus.op),
      .zero_i  (bus.zero),
      .ctrl_o  (w_ctrl)
   );

   // State register; reset lands in IF regardless of current state
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state_q <= S_IF;
      else       state_q <= state_d;
   end

   // Next-state: fixed paths per instruction family, HALT is absorbing
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            case (w_cls)
               CL_ALU:  state_d = S_EXE_AL;
               CL_BR:   state_d = S_EXE_BR;
               CL_LS:   state_d = S_EXE_LS;
               CL_HALT: state_d = S_HALT;
               default: state_d = S_IF;
            endcase
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_WB_AL:  state_d = S_IF;
         S_EXE_BR: state_d = S_IF;
         S_EXE_LS: state_d = S_MEM;
         S_MEM:    state_d = (bus.op == OP_LW) ? S_WB_LD : S_IF;
         S_WB_LD:  state_d = S_IF;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IF;
      endcase
   end

   // Counters: one retire per PC write, cycles frozen while halted
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         retired_q <= '0;
         cycles_q  <= '0;
      end else begin
         if (state_q != S_HALT) cycles_q  <= cycles_q + C_ONE;
         if (w_ctrl.PCWre)      retired_q <= retired_q + C_ONE;
      end
   end

   assign bus.PCWre     = w_ctrl.PCWre;
   assign bus.IRWre     = w_ctrl.IRWre;
   assign bus.InsMemRW  = w_ctrl.InsMemRW;
   assign bus.DataMemRW = w_ctrl.DataMemRW;
   assign bus.RegWre    = w_ctrl.RegWre;
   assign bus.ALUSrcB   = w_ctrl.ALUSrcB;
   assign bus.ExtSel    = w_ctrl.ExtSel;
   assign bus.WrRegDSrc = w_ctrl.WrRegDSrc;
   assign bus.ALUM2Reg  = w_ctrl.ALUM2Reg;
   assign bus.RegDst    = w_ctrl.RegDst;
   assign bus.PCSrc     = w_ctrl.PCSrc;
   assign bus.ALUOp     = w_ctrl.ALUOp;
   assign bus.state     = state_q;
   assign bus.retired   = retired_q;
   assign bus.cycles    = cycles_q;

endmodule
`default_nettype wire
